// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_REG = 0;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: writes clear, pend_set sets (set wins), entry 0 never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        pend_lookup
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (we0 && (waddr0 != '0)) pend_d[waddr0] = 1'b0;
        if (we1 && (waddr1 != '0)) pend_d[waddr1] = 1'b0;
        // Applied after the clears: a newly issued producer outranks a retiring one.
        if (pend_set) pend_d[pend_addr] = 1'b1;
        pend_d[RF_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            assign pend_lookup[gi] = pend_q[raddr[gi*ADDR_W +: ADDR_W]];
        end
    endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two posedge write ports, NUM_RD negedge-registered read ports.
// Optional combinational debug read enabled by REGFILE_DBG_PORT_EN.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
`endif
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD-1:0]        pend_lookup;
    logic [NUM_RD*DATA_W-1:0] rdata_q;
    logic [NUM_RD*DATA_W-1:0] rdata_d;
    logic [NUM_RD-1:0]        rpend_q;
    logic [NUM_RD-1:0]        rpend_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == RF_ZERO_REG) begin : g_zero
                assign mem_q[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] mem_d;

                // Port 1 is evaluated last so it wins a same-address collision.
                always_comb begin
                    mem_d = mem_q[gi];
                    if (we0 && (waddr0 == ADDR_W'(gi))) mem_d = wdata0;
                    if (we1 && (waddr1 == ADDR_W'(gi))) mem_d = wdata1;
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) mem_q[gi] <= '0;
                    else       mem_q[gi] <= mem_d;
                end
            end
        end
    endgenerate

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .we0         (we0),
        .waddr0      (waddr0),
        .we1         (we1),
        .waddr1      (waddr1),
        .pend_set    (pend_set),
        .pend_addr   (pend_addr),
        .raddr       (raddr),
        .pend_lookup (pend_lookup)
    );

    always_comb begin
        rdata_d = '0;
        rpend_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] rd_addr;
            rd_addr = raddr[k*ADDR_W +: ADDR_W];
            rdata_d[k*DATA_W +: DATA_W] = (rd_addr == '0) ? '0 : mem_q[rd_addr];
            rpend_d[k] = pend_lookup[k];
        end
    end

    // Sampling on the falling edge lets a same-cycle posedge write show up without a bypass.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            rpend_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            rpend_q <= rpend_d;
        end
    end

    assign rdata = rdata_q;
    assign rpend = rpend_q;

`ifdef REGFILE_DBG_PORT_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expected reads, a monitor checks them at each negedge.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             we0, we1, pend_set;
    logic [AW-1:0]    waddr0, waddr1, pend_addr;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rpend;
`ifdef REGFILE_DBG_PORT_EN
    logic [AW-1:0]    dbg_addr = '0;
    logic [DW-1:0]    dbg_data;
`endif

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .raddr     (raddr),
        .rdata     (rdata),
        .rpend     (rpend)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
`endif
    );

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
        logic        pend;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   neg_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: counts falling edges and checks every expectation due at this edge.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            #2;
            while (exp_q.size() > 0 && exp_q[0].due <= neg_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.due < neg_cnt) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL %s: stale expectation due %0d seen at %0d", e.name, e.due, neg_cnt);
                end else begin
                    check({e.name, " rdata"}, rdata[e.port*DW +: DW], e.data);
                    check({e.name, " rpend"}, 32'(rpend[e.port]), 32'(e.pend));
                end
            end
        end
    end

    // Drive point: just after a negedge; the read for these inputs lands on the next negedge.
    task automatic next_cycle();
        @(negedge clk);
        #1;
        we0 = 1'b0; we1 = 1'b0; pend_set = 1'b0;
        waddr0 = '0; waddr1 = '0; pend_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic rd(input int port, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic p, input string name);
        exp_t e;
        raddr[port*AW +: AW] = a;
        e.due  = neg_cnt + 1;
        e.port = port;
        e.data = d;
        e.pend = p;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        we0 = 1'b0; we1 = 1'b0; pend_set = 1'b0;
        waddr0 = '0; waddr1 = '0; pend_addr = '0;
        wdata0 = '0; wdata1 = '0; raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata[31:0], 32'h0);
        check("reset rpend", 32'(rpend), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // All addresses read back zero after reset on both ports.
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            rd(0, AW'(a), 32'h0, 1'b0, $sformatf("rst a%0d p0", a));
            rd(1, AW'(31 - a), 32'h0, 1'b0, $sformatf("rst a%0d p1", 31 - a));
        end

        next_cycle();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        rd(0, 5'd5, 32'hDEADBEEF, 1'b0, "wr/rd same cycle r5");
        rd(1, 5'd0, 32'h0, 1'b0, "r0 during write");

        next_cycle();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h22222222;
        rd(0, 5'd9, 32'h22222222, 1'b0, "collision r9");
        rd(1, 5'd5, 32'hDEADBEEF, 1'b0, "r5 hold");

        next_cycle();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        pend_set = 1'b1; pend_addr = 5'd0;
        rd(0, 5'd0, 32'h0, 1'b0, "write r0 discarded");
        rd(1, 5'd9, 32'h22222222, 1'b0, "r9 after collision");

        next_cycle();
        rd(0, 5'd0, 32'h0, 1'b0, "r0 pend stays 0");
        rd(1, 5'd7, 32'h0, 1'b0, "r7 before set");

        next_cycle();
        pend_set = 1'b1; pend_addr = 5'd7;
        rd(0, 5'd7, 32'h0, 1'b1, "r7 pend set");
        rd(1, 5'd9, 32'h22222222, 1'b0, "r9 unaffected");

        next_cycle();
        rd(0, 5'd7, 32'h0, 1'b1, "r7 pend held");

        next_cycle();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h7;
        rd(0, 5'd7, 32'h7, 1'b0, "r7 write clears");

        next_cycle();
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h77;
        pend_set = 1'b1; pend_addr = 5'd7;
        rd(0, 5'd7, 32'h77, 1'b1, "r7 set beats clear");
        rd(1, 5'd5, 32'hDEADBEEF, 1'b0, "r5 still");

        next_cycle();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
        rd(0, 5'd3, 32'hA5A5A5A5, 1'b0, "r3 written");
        rd(1, 5'd7, 32'h77, 1'b1, "r7 pend before reset");

        // Keep the same reads, then hit reset in the middle of the high phase.
        next_cycle();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset rdata p0", rdata[31:0], 32'h0);
        check("async reset rdata p1", rdata[63:32], 32'h0);
        check("async reset rpend", 32'(rpend), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        rd(0, 5'd3, 32'h0, 1'b0, "r3 after reset");
        rd(1, 5'd7, 32'h0, 1'b0, "r7 after reset");

        next_cycle();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678;
        rd(0, 5'd3, 32'h12345678, 1'b0, "first write after reset");

        next_cycle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
